multi_cycle_controller: RTL
===========================

// Module: multi_cycle_controller
// PURPOSE
//  Moore-FSM control unit for the 8-bit multi-cycle datapath. Generates every datapath control
//  strobe from the instruction fields held in IR and the ALU flags.
//  Sits directly upstream of the datapath and replaces the hand-driven control sequence.
//  Also holds the NZCV status register and evaluates conditional execution.
// PARAMETERS
//  STATE_W   4   width of the state register / State debug output
// PORTS
//  clk         in   1  single clock; all state updates on rising edge
//  rst         in   1  synchronous, active-high reset
//  Cond        in   4  IR condition field
//  Op          in   2  IR class: 00 data-proc, 01 memory, 10 branch, 11 undefined
//  Funct       in   5  DP: [3:0]=ALU cmd, [4]=S. MEM: [0]=L (1 LDR/0 STR), [1]=LDI.
//                      BR: [1:0] = 00 B, 01 BL, 10 BI
//  ALU_flags   in   4  {N,Z,C,V} from datapath ALU, valid in EXECUTE
//  PCWrite, MemWrite, IRWrite, RegWrite, ImmSrc, ALUSrcA   out  1  datapath controls
//  AdrSrc out 2; ALUControl out 4; ALUSrcB out 2; RegSrc out 3; ResultSrc out 2
//  State       out  STATE_W  current state code, for verification
// BEHAVIOUR
//  Reset: state<=FETCH, NZCV<=0000, CondEx<=0, RegSrc reg<=000.
//   While rst=1, PCWrite/MemWrite/IRWrite/RegWrite are forced 0.
//  Outputs are decoded combinationally from state plus registered decode info. Defaults:
//   all writes 0, ImmSrc=0, ALUSrcA=0, AdrSrc=00, ALUControl=0000, ALUSrcB=00, ResultSrc=10.
//  FETCH(0):   PCWrite=1 IRWrite=1 ALUSrcA=1 AdrSrc=00 ALUSrcB=10 ResultSrc=10 -> DECODE
//  DECODE(1):  ALUSrcA=1 ALUSrcB=10. Latch RegSrc: DP/LDR/LDI=100, STR=110, B=000, BL=001, BI=101.
//   Latch CondEx from Cond vs NZCV: 0000 EQ Z; 0001 NE !Z; 0010 CS C; 0011 CC !C;
//   0100 MI N; 0101 PL !N; 1110 AL 1; all other codes 0.
//   Next state: !CondEx or Op=11 or BR Funct=11 -> FETCH. Otherwise DP->EXECUTE,
//   MEM&LDI->LDI, MEM->MEMADR, B/BL->BRANCH, BI->BI.
//  EXECUTE(2): ALUControl=Funct[3:0] ALUSrcB=00 -> ALUWB. If Funct[4], NZCV<=ALU_flags at edge.
//  ALUWB(3):   ResultSrc=00 RegWrite=1 -> FETCH
//  MEMADR(4):  ImmSrc=0 ALUSrcB=01 ALUControl=0000 -> MEMREAD if L else MEMWRITE
//  MEMREAD(5): AdrSrc=01 ResultSrc=00 -> MEMWB
//  MEMWB(6):   ResultSrc=01 RegWrite=1 -> FETCH
//  MEMWRITE(7): AdrSrc=01 ResultSrc=00 MemWrite=1 -> FETCH
//  LDI(8):     ImmSrc=1 ALUSrcB=01 ResultSrc=11 RegWrite=1 -> FETCH
//  BRANCH(9):  PCWrite=1 ALUSrcB=01 ALUControl=0000 ResultSrc=10; RegWrite=1 iff BL -> FETCH
//  BI(10):     ALUSrcB=00 ResultSrc=11 PCWrite=1 -> FETCH
//  Latency in cycles incl. fetch: DP 4, LDR 5, STR 4, LDI 3, B/BL/BI 3, skipped/undefined 2.
//  RegSrc holds its DECODE value until the next DECODE. NZCV changes only in EXECUTE with S=1.
//  Unused state codes 11-15 -> FETCH with all writes 0.
//  rst mid-instruction aborts immediately: next state FETCH, NZCV cleared, no write issued.
// TESTING
//  1 rst=1 2 cycles, then release -> State=0 with all writes 0 during rst; PCWrite=IRWrite=1 cycle 1.
//  2 Op=00 Funct=10001 (SUB,S) Cond=1110, ALU_flags=0100 -> states 0,1,2,3;
//    ALUControl=0001 in EXECUTE; RegWrite=1 only in ALUWB; NZCV=0100 afterwards.
//  3 Op=01 Funct=00001 (LDR) -> states 0,1,4,5,6; AdrSrc=01 in 5, ResultSrc=01 and RegWrite in 6.
//    Then Funct=00000 (STR) -> 0,1,4,7 with MemWrite=1 only in state 7 and RegSrc=110.
//  4 Op=10 Funct=00001 (BL) -> states 0,1,9, RegSrc=001, PCWrite=RegWrite=1 in 9.
//    Then Funct=00010 (BI) -> 0,1,10 with ResultSrc=11 and PCWrite=1.
//  5 NZCV Z=0, Cond=0000 (EQ) on DP -> 0,1,0: no RegWrite or MemWrite, NZCV unchanged.
//    With Z=1 the same instruction executes fully.
//  6 Assert rst while in MEMREAD -> next cycle State=0, no RegWrite pulse, NZCV=0000.

Source files
------------

// File: rtl/multi_cycle_controller_if.sv
// ---------------------------------------------------------------------------
// multi_cycle_controller_if
//   Bundles the instruction fields, ALU flags and datapath control strobes
//   that pass between the multi-cycle controller and its datapath.
//   Ports (from the controller's side, modport slave):
//     in : Cond[3:0], Op[1:0], Funct[4:0], ALU_flags[3:0] ({N,Z,C,V})
//     out: PCWrite, MemWrite, IRWrite, RegWrite, ImmSrc, ALUSrcA,
//          AdrSrc[1:0], ALUControl[3:0], ALUSrcB[1:0], RegSrc[2:0],
//          ResultSrc[1:0]
//   modport master is the datapath / stimulus side.
// ---------------------------------------------------------------------------
interface multi_cycle_controller_if;
  logic [3:0] Cond;
  logic [1:0] Op;
  logic [4:0] Funct;
  logic [3:0] ALU_flags;

  logic       PCWrite;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegWrite;
  logic       ImmSrc;
  logic       ALUSrcA;
  logic [1:0] AdrSrc;
  logic [3:0] ALUControl;
  logic [1:0] ALUSrcB;
  logic [2:0] RegSrc;
  logic [1:0] ResultSrc;

  modport master (
    output Cond, Op, Funct, ALU_flags,
    input  PCWrite, MemWrite, IRWrite, RegWrite, ImmSrc, ALUSrcA,
           AdrSrc, ALUControl, ALUSrcB, RegSrc, ResultSrc
  );

  modport slave (
    input  Cond, Op, Funct, ALU_flags,
    output PCWrite, MemWrite, IRWrite, RegWrite, ImmSrc, ALUSrcA,
           AdrSrc, ALUControl, ALUSrcB, RegSrc, ResultSrc
  );
endinterface

// File: rtl/multi_cycle_controller.sv
// ---------------------------------------------------------------------------
// multi_cycle_controller
//   Moore control unit for the 8-bit multi-cycle datapath. Sequences each
//   instruction through FETCH/DECODE and the class-specific states, holds
//   the NZCV status register and evaluates the condition field in DECODE.
//   Ports:
//     clk   : single clock, rising edge
//     rst   : synchronous active-high reset
//     bus   : multi_cycle_controller_if.slave (IR fields, flags, strobes)
//     State : current state code (debug/verification)
//
//   state    | code | meaning
//   FETCH    |  0   | read instruction, PC <= PC+1
//   DECODE   |  1   | read registers, evaluate condition, latch RegSrc
//   EXECUTE  |  2   | data-processing ALU op, optional flag update
//   ALUWB    |  3   | write ALU result to register file
//   MEMADR   |  4   | compute memory address
//   MEMREAD  |  5   | read data memory
//   MEMWB    |  6   | write loaded data to register file
//   MEMWRITE |  7   | write data memory
//   LDI      |  8   | write immediate to register file
//   BRANCH   |  9   | PC <= target (link write for BL)
//   BI       | 10   | PC <= register-indirect target
// ---------------------------------------------------------------------------
module multi_cycle_controller #(
  parameter int STATE_W = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  multi_cycle_controller_if.slave bus,
  output logic [STATE_W-1:0]     State
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXECUTE  = 4'd2,
    S_ALUWB    = 4'd3,
    S_MEMADR   = 4'd4,
    S_MEMREAD  = 4'd5,
    S_MEMWB    = 4'd6,
    S_MEMWRITE = 4'd7,
    S_LDI      = 4'd8,
    S_BRANCH   = 4'd9,
    S_BI       = 4'd10
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] nzcv_q, nzcv_d;
  logic       cond_ex_q, cond_ex_d;
  logic [2:0] reg_src_q, reg_src_d;

  logic cond_pass;
  logic is_undef;
  logic unused_v_flag;

  // No condition code in this ISA looks at V; it is still stored.
  assign unused_v_flag = nzcv_q[0];

  always_comb begin
    cond_pass = 1'b0;
    case (bus.Cond)
      4'b0000: cond_pass =  nzcv_q[2];
      4'b0001: cond_pass = ~nzcv_q[2];
      4'b0010: cond_pass =  nzcv_q[1];
      4'b0011: cond_pass = ~nzcv_q[1];
      4'b0100: cond_pass =  nzcv_q[3];
      4'b0101: cond_pass = ~nzcv_q[3];
      4'b1110: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  end

  assign is_undef = (bus.Op == 2'b11) ||
                    ((bus.Op == 2'b10) && (bus.Funct[1:0] == 2'b11));

  always_comb begin
    state_d   = state_q;
    nzcv_d    = nzcv_q;
    cond_ex_d = cond_ex_q;
    reg_src_d = reg_src_q;

    bus.PCWrite    = 1'b0;
    bus.MemWrite   = 1'b0;
    bus.IRWrite    = 1'b0;
    bus.RegWrite   = 1'b0;
    bus.ImmSrc     = 1'b0;
    bus.ALUSrcA    = 1'b0;
    bus.AdrSrc     = 2'b00;
    bus.ALUControl = 4'b0000;
    bus.ALUSrcB    = 2'b00;
    bus.ResultSrc  = 2'b10;

    case (state_q)
      S_FETCH: begin
        bus.PCWrite = 1'b1;
        bus.IRWrite = 1'b1;
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = 2'b10;
        state_d     = S_DECODE;
      end
      S_DECODE: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = 2'b10;
        cond_ex_d   = cond_pass;
        // Undefined encodings leave the previous RegSrc in place.
        case (bus.Op)
          2'b00: reg_src_d = 3'b100;
          2'b01: reg_src_d = (bus.Funct[1] || bus.Funct[0]) ? 3'b100 : 3'b110;
          2'b10: begin
            case (bus.Funct[1:0])
              2'b00:   reg_src_d = 3'b000;
              2'b01:   reg_src_d = 3'b001;
              2'b10:   reg_src_d = 3'b101;
              default: reg_src_d = reg_src_q;
            endcase
          end
          default: reg_src_d = reg_src_q;
        endcase
        // The freshly evaluated condition decides; cond_ex_q is stale here.
        if (!cond_pass || is_undef) begin
          state_d = S_FETCH;
        end else begin
          case (bus.Op)
            2'b00:   state_d = S_EXECUTE;
            2'b01:   state_d = bus.Funct[1] ? S_LDI : S_MEMADR;
            default: state_d = (bus.Funct[1:0] == 2'b10) ? S_BI : S_BRANCH;
          endcase
        end
      end
      S_EXECUTE: begin
        bus.ALUControl = bus.Funct[3:0];
        bus.ALUSrcB    = 2'b00;
        if (bus.Funct[4]) nzcv_d = bus.ALU_flags;
        state_d        = S_ALUWB;
      end
      S_ALUWB: begin
        bus.ResultSrc = 2'b00;
        bus.RegWrite  = 1'b1;
        state_d       = S_FETCH;
      end
      S_MEMADR: begin
        bus.ImmSrc     = 1'b0;
        bus.ALUSrcB    = 2'b01;
        bus.ALUControl = 4'b0000;
        state_d        = bus.Funct[0] ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        bus.AdrSrc    = 2'b01;
        bus.ResultSrc = 2'b00;
        state_d       = S_MEMWB;
      end
      S_MEMWB: begin
        bus.ResultSrc = 2'b01;
        bus.RegWrite  = 1'b1;
        state_d       = S_FETCH;
      end
      S_MEMWRITE: begin
        bus.AdrSrc    = 2'b01;
        bus.ResultSrc = 2'b00;
        bus.MemWrite  = 1'b1;
        state_d       = S_FETCH;
      end
      S_LDI: begin
        bus.ImmSrc    = 1'b1;
        bus.ALUSrcB   = 2'b01;
        bus.ResultSrc = 2'b11;
        bus.RegWrite  = 1'b1;
        state_d       = S_FETCH;
      end
      S_BRANCH: begin
        bus.PCWrite    = 1'b1;
        bus.ALUSrcB    = 2'b01;
        bus.ALUControl = 4'b0000;
        bus.ResultSrc  = 2'b10;
        bus.RegWrite   = (bus.Funct[1:0] == 2'b01);
        state_d        = S_FETCH;
      end
      S_BI: begin
        bus.ALUSrcB   = 2'b00;
        bus.ResultSrc = 2'b11;
        bus.PCWrite   = 1'b1;
        state_d       = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase

    // Post-decode writes are qualified by the latched condition as a guard
    // against entering an execute state without a passing condition.
    if ((state_q != S_FETCH) && (state_q != S_DECODE) && !cond_ex_q) begin
      bus.PCWrite  = 1'b0;
      bus.MemWrite = 1'b0;
      bus.RegWrite = 1'b0;
    end

    // Reset suppresses every architectural write in the same cycle.
    if (rst) begin
      bus.PCWrite  = 1'b0;
      bus.MemWrite = 1'b0;
      bus.IRWrite  = 1'b0;
      bus.RegWrite = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      nzcv_q    <= 4'b0000;
      cond_ex_q <= 1'b0;
      reg_src_q <= 3'b000;
    end else begin
      state_q   <= state_d;
      nzcv_q    <= nzcv_d;
      cond_ex_q <= cond_ex_d;
      reg_src_q <= reg_src_d;
    end
  end

  assign bus.RegSrc = reg_src_q;
  assign State      = STATE_W'(state_q);

endmodule
